// File: rtl/stream_packetizer.sv
// Frames samples read from an AXI4-Stream FIFO into fixed-length packets: SYNC_WORD, sequence
// number, PACKET_LEN samples; a starved packet is completed with PAD_WORD after TIMEOUT cycles.
module stream_packetizer #(
    parameter int               WIDTH      = 16,
    parameter int               PACKET_LEN = 256,
    parameter int               TIMEOUT    = 1024,
    parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(16'hA5A5),
    parameter logic [WIDTH-1:0] PAD_WORD   = WIDTH'(16'h0000)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tlast,
    output logic             busy,
    output logic             pkt_done,
    output logic             pad_active
);

    localparam int                CW           = $clog2(PACKET_LEN + 1);
    localparam logic [CW-1:0]     LAST_BEAT    = CW'(PACKET_LEN - 1);
    localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        DATA,
        PAD
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] seq, seq_nxt;
    logic [WIDTH-1:0] tdata_nxt;
    logic             tvalid_nxt, tlast_nxt;
    logic [CW-1:0]    beat_cnt, beat_nxt;
    logic [31:0]      idle_cnt, idle_nxt;
    logic             free;

    // The single output register may only be reloaded once its current beat has left.
    assign free       = !m_tvalid || m_tready;
    assign s_tready   = (state == DATA) && free;
    assign busy       = (state != IDLE);
    assign pad_active = (state == PAD);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_nxt  = state;
        tvalid_nxt = m_tvalid;
        tdata_nxt  = m_tdata;
        tlast_nxt  = m_tlast;
        seq_nxt    = seq;
        beat_nxt   = beat_cnt;
        idle_nxt   = idle_cnt;
        if (free) begin
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    if (s_tvalid) begin
                        tvalid_nxt = 1'b1;
                        tdata_nxt  = SYNC_WORD;
                        state_nxt  = SEQ;
                    end
                end
                SEQ: begin
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = seq;
                    beat_nxt   = '0;
                    idle_nxt   = '0;
                    state_nxt  = DATA;
                end
                DATA: begin
                    if (s_tvalid) begin
                        // A sample arriving on the timeout cycle still wins over padding.
                        tvalid_nxt = 1'b1;
                        tdata_nxt  = s_tdata;
                        beat_nxt   = beat_cnt + 1'b1;
                        idle_nxt   = '0;
                        if (beat_cnt == LAST_BEAT) begin
                            tlast_nxt = 1'b1;
                            seq_nxt   = seq + 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        if (idle_cnt != '1) begin
                            idle_nxt = idle_cnt + 1'b1;
                        end
                        if (TIMEOUT != 0 && idle_cnt == TIMEOUT_LAST) begin
                            state_nxt = PAD;
                        end
                    end
                end
                PAD: begin
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = PAD_WORD;
                    beat_nxt   = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        tlast_nxt = 1'b1;
                        seq_nxt   = seq + 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (!resetn) begin
            state    <= IDLE;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            seq      <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            m_tvalid <= tvalid_nxt;
            m_tdata  <= tdata_nxt;
            m_tlast  <= tlast_nxt;
            seq      <= seq_nxt;
            beat_cnt <= beat_nxt;
            idle_cnt <= idle_nxt;
            pkt_done <= m_tvalid && m_tready && m_tlast;
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed bench for stream_packetizer: a 16-bit build (PACKET_LEN=4, TIMEOUT=8) and an 8-bit
// build (PACKET_LEN=1) used for sequence-number wrap.
module tb_stream_packetizer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        busy, pkt_done, pad_active;

    logic        resetn8 = 1'b0;
    logic        s8_tvalid = 1'b1;
    logic        s8_tready;
    logic [7:0]  s8_tdata = 8'h3C;
    logic        m8_tvalid;
    logic        m8_tready = 1'b1;
    logic [7:0]  m8_tdata;
    logic        m8_tlast;
    logic        busy8, pkt_done8, pad8;

    always #5 clk = ~clk;

    stream_packetizer #(.WIDTH(16), .PACKET_LEN(4), .TIMEOUT(8),
                        .SYNC_WORD(16'hA5A5), .PAD_WORD(16'h0000)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .pkt_done(pkt_done), .pad_active(pad_active)
    );

    stream_packetizer #(.WIDTH(8), .PACKET_LEN(1), .TIMEOUT(0),
                        .SYNC_WORD(8'hA5), .PAD_WORD(8'h00)) dut8 (
        .clk(clk), .resetn(resetn8),
        .s_tvalid(s8_tvalid), .s_tready(s8_tready), .s_tdata(s8_tdata),
        .m_tvalid(m8_tvalid), .m_tready(m8_tready), .m_tdata(m8_tdata), .m_tlast(m8_tlast),
        .busy(busy8), .pkt_done(pkt_done8), .pad_active(pad8)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    logic [15:0] src_q[$];
    logic [16:0] got_q[$];
    int          got_cyc[$];
    logic [16:0] exp_q[$];
    logic        throttle = 1'b0;
    int          cyc = 0;
    int          pkt_cnt = 0;
    int          pad_cyc = 0;
    int          done_double = 0;
    logic        prev_done = 1'b0;
    logic        prev_hold = 1'b0;
    logic [16:0] prev_word = '0;

    // Source FIFO model and downstream ready, updated just after each edge.
    always @(posedge clk) begin
        #1;
        s_tvalid = (src_q.size() != 0);
        s_tdata  = (src_q.size() != 0) ? src_q[0] : 16'h0;
        m_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (resetn) begin
            if (s_tvalid && s_tready) void'(src_q.pop_front());
            if (prev_hold) begin
                check("hold_valid", {31'b0, m_tvalid}, 32'd1);
                check("hold_word", {15'b0, m_tlast, m_tdata}, {15'b0, prev_word});
            end
            prev_hold = m_tvalid && !m_tready;
            prev_word = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tlast, m_tdata});
                got_cyc.push_back(cyc);
            end
            if (pkt_done) pkt_cnt++;
            if (pkt_done && prev_done) done_double++;
            prev_done = pkt_done;
            if (pad_active) pad_cyc++;
        end else begin
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end
    end

    logic [7:0] seq8[0:299];
    int         pkt8 = 0;
    int         pos8 = 0;
    int         err8 = 0;

    always @(negedge clk) begin
        if (resetn8 && m8_tvalid && m8_tready) begin
            if (pos8 == 0 && m8_tdata != 8'hA5) err8++;
            if (pos8 == 1 && pkt8 < 300) seq8[pkt8] = m8_tdata;
            if (pos8 == 2 && m8_tdata != 8'h3C) err8++;
            if (m8_tlast != (pos8 == 2)) err8++;
            if (pos8 == 2) begin
                pos8 = 0;
                pkt8++;
            end else begin
                pos8++;
            end
        end
    end

    task automatic do_reset();
        resetn   = 1'b0;
        throttle = 1'b0;
        src_q.delete();
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        got_q.delete();
        got_cyc.delete();
        pkt_cnt     = 0;
        pad_cyc     = 0;
        done_double = 0;
    endtask

    task automatic exp_add(input logic [15:0] word, input logic last);
        exp_q.push_back({last, word});
    endtask

    task automatic wait_pkts(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && pkt_cnt < n; i++) @(posedge clk);
        #3;
        check(tag, {31'b0, pkt_cnt >= n}, 32'd1);
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check(tag, {15'b0, got_q[i]}, {15'b0, exp_q[i]});
            end
        end
        exp_q.delete();
    endtask

    initial begin
        // 1: reset state, single packet, header latency
        do_reset();
        check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("rst_tdata", {16'b0, m_tdata}, 32'd0);
        check("rst_tlast", {31'b0, m_tlast}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_s_tready", {31'b0, s_tready}, 32'd0);
        check("rst_pkt_done", {31'b0, pkt_done}, 32'd0);
        for (int i = 1; i <= 4; i++) src_q.push_back(16'(i));
        @(posedge clk); #3;
        check("t1_sync_not_yet", {31'b0, m_tvalid}, 32'd0);
        @(posedge clk); #3;
        check("t1_sync_valid", {31'b0, m_tvalid}, 32'd1);
        check("t1_sync_data", {16'b0, m_tdata}, 32'h0000A5A5);
        check("t1_busy", {31'b0, busy}, 32'd1);
        wait_pkts("t1_done_seen", 1, 100);
        repeat (3) @(posedge clk);
        #3;
        check("t1_busy_after", {31'b0, busy}, 32'd0);
        check("t1_tvalid_after", {31'b0, m_tvalid}, 32'd0);
        check("t1_pkt_cnt", pkt_cnt, 32'd1);
        check("t1_done_width", done_double, 32'd0);
        exp_add(16'hA5A5, 0); exp_add(16'h0000, 0);
        exp_add(16'h0001, 0); exp_add(16'h0002, 0); exp_add(16'h0003, 0); exp_add(16'h0004, 1);
        compare_beats("t1_beats");

        // 2: two back-to-back packets, no gaps
        do_reset();
        for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
        wait_pkts("t2_done_seen", 2, 200);
        exp_add(16'hA5A5, 0); exp_add(16'h0000, 0);
        for (int i = 1; i <= 4; i++) exp_add(16'(i), i == 4);
        exp_add(16'hA5A5, 0); exp_add(16'h0001, 0);
        for (int i = 5; i <= 8; i++) exp_add(16'(i), i == 8);
        if (got_cyc.size() == 12) check("t2_no_gaps", got_cyc[11] - got_cyc[0], 32'd11);
        else check("t2_beat_count", got_cyc.size(), 32'd12);
        compare_beats("t2_beats");

        // 3: random downstream throttle; hold checks run in the monitor
        do_reset();
        throttle = 1'b1;
        for (int i = 0; i < 8; i++) src_q.push_back(16'h1000 + 16'(i));
        wait_pkts("t3_done_seen", 2, 600);
        throttle = 1'b0;
        exp_add(16'hA5A5, 0); exp_add(16'h0000, 0);
        for (int i = 0; i < 4; i++) exp_add(16'h1000 + 16'(i), i == 3);
        exp_add(16'hA5A5, 0); exp_add(16'h0001, 0);
        for (int i = 4; i < 8; i++) exp_add(16'h1000 + 16'(i), i == 7);
        compare_beats("t3_beats");

        // 4: starvation timeout, padding, late sample goes to the next packet
        do_reset();
        src_q.push_back(16'h0011);
        src_q.push_back(16'h0022);
        for (int i = 0; i < 100 && !pad_active; i++) begin
            @(posedge clk); #3;
        end
        check("t4_pad_seen", {31'b0, pad_active}, 32'd1);
        check("t4_pad_no_sready", {31'b0, s_tready}, 32'd0);
        src_q.push_back(16'h0099);
        src_q.push_back(16'h00AA);
        src_q.push_back(16'h00BB);
        src_q.push_back(16'h00CC);
        wait_pkts("t4_done_seen", 2, 300);
        check("t4_pad_cycles", pad_cyc, 32'd2);
        if (got_cyc.size() >= 5) check("t4_timeout_gap", got_cyc[4] - got_cyc[3], 32'd9);
        exp_add(16'hA5A5, 0); exp_add(16'h0000, 0);
        exp_add(16'h0011, 0); exp_add(16'h0022, 0); exp_add(16'h0000, 0); exp_add(16'h0000, 1);
        exp_add(16'hA5A5, 0); exp_add(16'h0001, 0);
        exp_add(16'h0099, 0); exp_add(16'h00AA, 0); exp_add(16'h00BB, 0); exp_add(16'h00CC, 1);
        compare_beats("t4_beats");

        // 5: reset mid-packet abandons the frame and restarts seq
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(16'(i));
        for (int i = 0; i < 100 && got_q.size() < 3; i++) @(negedge clk);
        @(posedge clk); #3;
        resetn = 1'b0;
        src_q.delete();
        @(posedge clk); #3;
        check("t5_tvalid_rst", {31'b0, m_tvalid}, 32'd0);
        check("t5_busy_rst", {31'b0, busy}, 32'd0);
        check("t5_no_tlast", pkt_cnt, 32'd0);
        resetn = 1'b1;
        got_q.delete();
        got_cyc.delete();
        pkt_cnt = 0;
        for (int i = 5; i <= 8; i++) src_q.push_back(16'(i));
        wait_pkts("t5_done_seen", 1, 100);
        exp_add(16'hA5A5, 0); exp_add(16'h0000, 0);
        for (int i = 5; i <= 8; i++) exp_add(16'(i), i == 8);
        compare_beats("t5_beats");

        // 6: 8-bit build, PACKET_LEN=1, sequence wraps FF -> 00
        @(posedge clk); #3;
        resetn8 = 1'b1;
        for (int i = 0; i < 1500 && pkt8 < 258; i++) @(posedge clk);
        #3;
        check("t6_done_seen", {31'b0, pkt8 >= 258}, 32'd1);
        check("t6_seq0", {24'b0, seq8[0]}, 32'h00);
        check("t6_seq1", {24'b0, seq8[1]}, 32'h01);
        check("t6_seq255", {24'b0, seq8[255]}, 32'hFF);
        check("t6_seq256", {24'b0, seq8[256]}, 32'h00);
        check("t6_frame_errors", err8, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
